// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through FIFO one word at a time and
// sends each word as a UART frame: start bit, data LSB first, optional parity,
// then one or two stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_cts_n,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_pop,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Reject parameter sets the bit timing cannot support.
  generate
    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_nx;
  logic [BAUD_W-1:0]     baud, baud_nx;
  logic [BIT_W-1:0]      bitc, bitc_nx;
  logic [DATA_WIDTH-1:0] shift, shift_nx;
  logic                  par, par_nx;
  logic                  tx, tx_nx;
  logic                  pop, done;
  logic                  launch, bit_end;

  // Reset is folded into launch so the pop strobe drops with reset at once.
  assign launch  = i_rst_n & i_en & ~i_cts_n & ~i_fifo_empty;
  assign bit_end = (baud == BAUD_LAST);

  // State register and datapath; reset leaves the line idle high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      baud  <= '0;
      bitc  <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_nx;
      baud  <= baud_nx;
      bitc  <= bitc_nx;
      shift <= shift_nx;
      par   <= par_nx;
      tx    <= tx_nx;
    end
  end

  // Next state, next line level and the pop/done strobes. tx_nx is the level of
  // the bit that starts on the next cycle, so o_tx needs no output decode.
  always_comb begin
    state_nx = state;
    baud_nx  = (state == S_IDLE || bit_end) ? '0 : baud + 1'b1;
    bitc_nx  = bitc;
    shift_nx = shift;
    par_nx   = par;
    tx_nx    = tx;
    pop      = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx_nx = 1'b1;
        if (launch) begin
          pop      = 1'b1;
          shift_nx = i_fifo_data;
          par_nx   = (^i_fifo_data) ^ 1'(PARITY_ODD);
          bitc_nx  = '0;
          tx_nx    = 1'b0;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_nx    = shift[0];
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_nx = shift >> 1;
          if (bitc == DATA_LAST) begin
            bitc_nx = '0;
            if (PARITY_EN != 0) begin
              tx_nx    = par;
              state_nx = S_PARITY;
            end else begin
              tx_nx    = 1'b1;
              state_nx = S_STOP;
            end
          end else begin
            bitc_nx = bitc + 1'b1;
            tx_nx   = shift_nx[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          bitc_nx  = '0;
          tx_nx    = 1'b1;
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bitc == STOP_LAST) begin
            done     = 1'b1;
            bitc_nx  = '0;
            state_nx = S_IDLE;
          end else begin
            bitc_nx = bitc + 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign o_fifo_pop   = pop;
  assign o_tx         = tx;
  assign o_busy       = (state != S_IDLE);
  assign o_frame_done = done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity/1 stop, even parity/2 stop,
// odd parity/1 stop) fed from bench FIFOs, checked every cycle against a
// frame-level model plus directed literal expectations.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int NI  = 3;
  localparam logic [2:0] PEN  = 3'b110;
  localparam logic [2:0] PODD = 3'b100;
  localparam logic [2:0] S2   = 3'b010;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           cts_n;
  logic [NI-1:0]  fempty;
  logic [7:0]     fdata [NI];
  logic [NI-1:0]  pop, tx, busy, done;

  logic [7:0]     fmem [NI][32];
  int             head [NI];
  int             tail [NI];
  int             rem  [NI];
  logic           fb   [NI][12];
  int             cyc    = 0;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    fifo_uart_tx #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PEN[g] ? 1 : 0),
      .PARITY_ODD  (PODD[g] ? 1 : 0),
      .STOP_BITS   (S2[g] ? 2 : 1)
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .i_cts_n     (cts_n),
      .i_fifo_empty(fempty[g]),
      .i_fifo_data (fdata[g]),
      .o_fifo_pop  (pop[g]),
      .o_tx        (tx[g]),
      .o_busy      (busy[g]),
      .o_frame_done(done[g])
    );
  end

  function automatic int flen(input int i);
    return CPB * (9 + (PEN[i] ? 1 : 0) + (S2[i] ? 2 : 1));
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // FIFO read side: first-word-fall-through view of each bench queue.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NI; i++) begin
      fempty[i] = (head[i] == tail[i]);
      fdata[i]  = fmem[i][head[i] % 32];
    end
  end

  // Frame-level model: a launch builds the expected bit list; each later cycle
  // the line level is bit (cycle_in_frame / CPB) of that list.
  always @(negedge clk) begin
    logic etx, ebusy, edone, epop;
    int   idx;
    for (int i = 0; i < NI; i++) begin
      etx = 1'b1; ebusy = 1'b0; edone = 1'b0; epop = 1'b0;
      if (!rst_n) begin
        rem[i] = 0;
      end else if (rem[i] == 0) begin
        epop = en & ~cts_n & ~fempty[i];
        if (epop) begin
          for (int k = 0; k < 12; k++) fb[i][k] = 1'b1;
          fb[i][0] = 1'b0;
          for (int k = 0; k < 8; k++) fb[i][k+1] = fdata[i][k];
          if (PEN[i]) fb[i][9] = (^fdata[i]) ^ PODD[i];
          rem[i]  = flen(i);
          head[i] = head[i] + 1;
        end
      end else begin
        idx    = flen(i) - rem[i];
        etx    = fb[i][idx / CPB];
        ebusy  = 1'b1;
        edone  = (rem[i] == 1);
        rem[i] = rem[i] - 1;
      end
      chk($sformatf("tx[%0d] cyc %0d", i, cyc), int'(tx[i]), int'(etx));
      chk($sformatf("busy[%0d] cyc %0d", i, cyc), int'(busy[i]), int'(ebusy));
      chk($sformatf("done[%0d] cyc %0d", i, cyc), int'(done[i]), int'(edone));
      chk($sformatf("pop[%0d] cyc %0d", i, cyc), int'(pop[i]), int'(epop));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int i, input logic [7:0] d);
    @(posedge clk); #1;
    fmem[i][tail[i] % 32] = d;
    tail[i] = tail[i] + 1;
  endtask

  task automatic set_cts(input logic v);
    @(posedge clk); #1;
    cts_n = v;
  endtask

  task automatic wait_pop(input int i, output int pc);
    pc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (pop[i]) begin pc = cyc; break; end
    end
    if (pc < 0) chk($sformatf("pop_timeout[%0d]", i), 0, 1);
  endtask

  task automatic wait_done(input int i, output int dc);
    dc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done[i]) begin dc = cyc; break; end
    end
    if (dc < 0) chk($sformatf("done_timeout[%0d]", i), 0, 1);
  endtask

  // Samples f cycles after a pop: mid-bit levels, busy count, done position.
  task automatic probe(input int i, input int f, output logic [11:0] seq,
                       output int dn, output int bc);
    seq = '0; dn = 0; bc = 0;
    for (int n = 1; n <= f; n++) begin
      @(negedge clk);
      if (busy[i]) bc++;
      if (done[i]) dn = n;
      if (n % 4 == 2) seq[n/4] = tx[i];
    end
  endtask

  initial begin
    logic [11:0] seq;
    int          pc, p0, p1, p2, dc, dn, bc, npop, nlow;
    logic [7:0]  b0, b1, b2;
    for (int i = 0; i < NI; i++) begin
      head[i] = 0; tail[i] = 0; rem[i] = 0; fempty[i] = 1'b1; fdata[i] = '0;
    end
    rst_n = 1'b0; en = 1'b1; cts_n = 1'b0;

    // Reset: word waiting and launch conditions met, yet no pop and idle line.
    repeat (2) @(posedge clk);
    push(0, 8'hA5);
    @(negedge clk);
    chk("rst_tx", int'(tx[0]), 1);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_pop", int'(pop[0]), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 0xA5, no parity, one stop bit.
    wait_pop(0, pc);
    probe(0, 40, seq, dn, bc);
    chk("t1_bits", int'(seq[9:0]), 'h34A);
    chk("t1_done_at", dn, 40);
    chk("t1_busy_cycles", bc, 40);

    // Empty FIFO on the 2-stop instance: nothing launches.
    npop = 0;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (pop[1]) npop++; end
    chk("t6_no_pop_empty", npop, 0);
    push(1, 8'hA5);
    @(negedge clk);
    chk("t6_pop_first_cycle", int'(pop[1]), 1);
    probe(1, 48, seq, dn, bc);
    chk("t2_even_a5_par", int'(seq[9]), 0);
    chk("t6_stop1", int'(seq[10]), 1);
    chk("t6_stop2", int'(seq[11]), 1);
    chk("t6_done_at", dn, 48);

    // Odd parity, 0xA5.
    push(2, 8'hA5);
    wait_pop(2, pc);
    probe(2, 44, seq, dn, bc);
    chk("t2_odd_a5_par", int'(seq[9]), 1);
    chk("t2_odd_done_at", dn, 44);
    chk("t2_odd_busy", bc, 44);

    // 0x01 on both parity instances.
    push(1, 8'h01);
    wait_pop(1, pc);
    probe(1, 48, seq, dn, bc);
    chk("t2_even_01_par", int'(seq[9]), 1);
    chk("t2_even_01_byte", int'(seq[8:1]), 'h01);
    push(2, 8'h01);
    wait_pop(2, pc);
    probe(2, 44, seq, dn, bc);
    chk("t2_odd_01_par", int'(seq[9]), 0);

    // Three queued words, back to back.
    set_cts(1'b1);
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    set_cts(1'b0);
    wait_pop(0, p0); probe(0, 40, seq, dn, bc); b0 = seq[8:1];
    wait_pop(0, p1); probe(0, 40, seq, dn, bc); b1 = seq[8:1];
    wait_pop(0, p2); probe(0, 40, seq, dn, bc); b2 = seq[8:1];
    chk("t3_gap", p1 - p0, 41);
    chk("t3_span", p2 + dn - p0, 122);
    chk("t3_byte0", int'(b0), 'h11);
    chk("t3_byte1", int'(b1), 'h22);
    chk("t3_byte2", int'(b2), 'h33);
    npop = 0;
    for (int n = 0; n < 10; n++) begin @(negedge clk); if (pop[0]) npop++; end
    chk("t3_no_extra_pop", npop, 0);

    // CTS raised mid-frame: frame completes, next launch waits for CTS.
    set_cts(1'b1);
    push(0, 8'h3C); push(0, 8'hC3);
    set_cts(1'b0);
    wait_pop(0, pc);
    repeat (10) @(posedge clk);
    #1 cts_n = 1'b1;
    wait_done(0, dc);
    chk("t4_frame_len", dc - pc, 40);
    npop = 0; nlow = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (pop[0]) npop++;
      if (!tx[0]) nlow++;
    end
    chk("t4_blocked_pops", npop, 0);
    chk("t4_line_low_cycles", nlow, 0);
    set_cts(1'b0);
    @(negedge clk);
    chk("t4_pop_on_cts", int'(pop[0]), 1);
    @(negedge clk);
    chk("t4_start_next", int'(tx[0]), 0);
    wait_done(0, dc);

    // Reset during data bit 3, then a clean frame.
    push(0, 8'h5A);
    wait_pop(0, pc);
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_tx", int'(tx[0]), 1);
    chk("t5_async_busy", int'(busy[0]), 0);
    chk("t5_async_pop", int'(pop[0]), 0);
    push(0, 8'h96);
    @(negedge clk);
    chk("t5_pop_in_reset", int'(pop[0]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_pop_after_rst", int'(pop[0]), 1);
    probe(0, 40, seq, dn, bc);
    chk("t5_start", int'(seq[0]), 0);
    chk("t5_byte", int'(seq[8:1]), 'h96);
    chk("t5_stop", int'(seq[9]), 1);
    chk("t5_done_at", dn, 40);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
